// File: rtl/ad100_mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Fetch and data ports share the RAM. Requests are granted combinationally
// in IDLE. A read then spends one RD cycle returning data to its owner.
// Writes complete in the grant cycle. Ties go to the requester not served last.
//
//   state | meaning
//   IDLE  | RAM free, a pending request is granted this cycle
//   RD    | read data from the previous grant is returned to owner
module ad100_mem_arbiter #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic [CW-1:0] conflict_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_RD = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data port owns the RD cycle
  logic          last_q, last_d;     // 1 = data port was granted last
  logic [CW-1:0] cnt_q, cnt_d;
  logic          idle;
  logic          gnt_f;
  logic          gnt_d;
  logic          held;

  // Grant decision; gated by rst_n so nothing is granted while reset is held.
  assign idle  = (state_q == S_IDLE) && rst_n;
  assign gnt_f = idle && if_req && (!d_req || last_q);
  assign gnt_d = idle && d_req && !gnt_f;
  assign held  = (if_req && !gnt_f) || (d_req && !gnt_d);

  // State register, owner tracking and saturating conflict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: reads enter RD for one cycle; writes stay in IDLE.
  always_comb begin
    state_d = S_IDLE;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (gnt_f) begin
      state_d = S_RD;
      owner_d = 1'b0;
      last_d  = 1'b0;
    end else if (gnt_d) begin
      last_d  = 1'b1;
      owner_d = 1'b1;
      if (!d_we) state_d = S_RD;
    end
    if (held && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Outputs: RAM drive during grants, read data only while its rvalid is high.
  always_comb begin
    if_gnt    = gnt_f;
    d_gnt     = gnt_d;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    busy      = (state_q == S_RD);
    if (gnt_f) begin
      ram_en   = 1'b1;
      ram_addr = if_addr;
    end else if (gnt_d) begin
      ram_en   = 1'b1;
      ram_addr = d_addr;
      if (d_we) begin
        ram_we    = d_be;
        ram_wdata = d_wdata;
      end
    end
    if (state_q == S_RD) begin
      if (owner_q) begin
        d_rvalid = 1'b1;
        d_rdata  = ram_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = ram_rdata;
      end
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ad100_mem_arbiter.sv
// Self-checking bench for ad100_mem_arbiter: directed scenarios followed by
// random traffic, compared cycle by cycle against a transaction-level model.
module tb_ad100_mem_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;
  logic [CW-1:0] conflict_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ad100_mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  // Synchronous RAM seen by the DUT, with a preload port for the bench.
  logic [31:0] tb_mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      tb_mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) tb_mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= tb_mem[ram_addr[7:0]];
    end
  end

  // Reference model: memory image, one outstanding read, fairness, counter.
  logic [31:0] ref_mem [256];
  bit          m_pend;
  bit          m_own_d;
  bit          m_last_d;
  logic [31:0] m_pdata;
  int          m_cnt;
  bit          g_f, g_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend   = 1'b0;
    m_own_d  = 1'b0;
    m_last_d = 1'b1;
    m_cnt    = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    bit wf, wd, held, wr;
    logic [AW-1:0] ea;
    @(negedge clk);
    wf = 1'b0;
    wd = 1'b0;
    if (!m_pend) begin
      if (if_req && d_req) begin
        wf = m_last_d;
        wd = !m_last_d;
      end else begin
        wf = if_req;
        wd = d_req;
      end
    end
    held = (if_req && !wf) || (d_req && !wd);
    wr   = wd && d_we;
    ea   = wf ? if_addr : (wd ? d_addr : '0);
    chk("if_gnt", 64'(if_gnt), 64'(wf));
    chk("d_gnt", 64'(d_gnt), 64'(wd));
    chk("ram_en", 64'(ram_en), 64'(wf | wd));
    chk("ram_addr", 64'(ram_addr), 64'(ea));
    chk("ram_we", 64'(ram_we), 64'(wr ? d_be : 4'b0000));
    if (!(wf || (wd && !d_we)))
      chk("ram_wdata", 64'(ram_wdata), 64'(wr ? d_wdata : 32'h0));
    chk("busy", 64'(busy), 64'(m_pend));
    chk("if_rvalid", 64'(if_rvalid), 64'(m_pend && !m_own_d));
    chk("if_rdata", 64'(if_rdata), 64'((m_pend && !m_own_d) ? m_pdata : 32'h0));
    chk("d_rvalid", 64'(d_rvalid), 64'(m_pend && m_own_d));
    chk("d_rdata", 64'(d_rdata), 64'((m_pend && m_own_d) ? m_pdata : 32'h0));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    @(posedge clk);
    if (held && m_cnt < 65535) m_cnt++;
    m_pend = 1'b0;
    if (wf) begin
      m_pend   = 1'b1;
      m_own_d  = 1'b0;
      m_pdata  = ref_mem[if_addr[7:0]];
      m_last_d = 1'b0;
    end
    if (wd) begin
      m_last_d = 1'b1;
      if (d_we) begin
        for (int b = 0; b < 4; b++)
          if (d_be[b]) ref_mem[d_addr[7:0]][b*8 +: 8] = d_wdata[b*8 +: 8];
      end else begin
        m_pend  = 1'b1;
        m_own_d = 1'b1;
        m_pdata = ref_mem[d_addr[7:0]];
      end
    end
    g_f = wf;
    g_d = wd;
    #1;
  endtask

  // Assert reset mid-cycle, check its immediate effect, release before next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_if_gnt", 64'(if_gnt), 64'(0));
    chk("rst_d_gnt", 64'(d_gnt), 64'(0));
    chk("rst_ram_en", 64'(ram_en), 64'(0));
    chk("rst_ram_we", 64'(ram_we), 64'(0));
    chk("rst_if_rvalid", 64'(if_rvalid), 64'(0));
    chk("rst_d_rvalid", 64'(d_rvalid), 64'(0));
    chk("rst_if_rdata", 64'(if_rdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cnt", 64'(conflict_cnt), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    if_req  = 1'b1;
    if_addr = 30'h10;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'b0000;
    d_addr  = '0;
    d_wdata = '0;
    pl_en   = 1'b1;
    pl_addr = '0;
    pl_data = '0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      pl_addr = 8'(i);
      pl_data = (i == 16) ? 32'h0000_0013 : (i == 0) ? 32'h1122_3344 : $urandom;
      ref_mem[i] = pl_data;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;
    do_reset();

    // Fetch-only read, granted in the first cycle after reset release.
    if_req  = 1'b1;
    if_addr = 30'h10;
    cycle();
    chk("r25_gnt", 64'(g_f), 64'(1));
    if_req = 1'b0;
    chk("r25_rvalid", 64'(if_rvalid), 64'(1));
    chk("r25_rdata", 64'(if_rdata), 64'(32'h13));
    chk("r25_busy", 64'(busy), 64'(1));
    cycle();

    // Simultaneous requests after reset: fetch first, data after RD gap.
    do_reset();
    if_req = 1'b1; if_addr = 30'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h0;
    cycle();
    if_req = 1'b0;
    cycle();
    cycle();
    chk("r26_dgnt", 64'(g_d), 64'(1));
    chk("r26_cnt", 64'(conflict_cnt), 64'(2));
    d_req = 1'b0;
    cycle();

    // Partial write then read back.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 30'h0; d_wdata = 32'hAABB_CCDD;
    cycle();
    d_we = 1'b0; d_be = 4'b0000;
    cycle();
    d_req = 1'b0;
    chk("r27_rdata", 64'(d_rdata), 64'(32'h1122_CCDD));
    cycle();

    // Byte-enable 0000 write: granted, nothing written.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0000; d_addr = 30'h5; d_wdata = 32'hFFFF_FFFF;
    cycle();
    d_we = 1'b0;
    cycle();
    d_req = 1'b0;
    cycle();

    // Continuous dual requests: alternating grants with RD gaps.
    if_req = 1'b1; if_addr = 30'h33;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h44;
    for (int i = 0; i < 8; i++) cycle();

    // Reset during RD drops the pending response.
    if_req = 1'b0; d_req = 1'b0;
    cycle();
    cycle();
    if_req = 1'b1; if_addr = 30'h10;
    cycle();
    if_req = 1'b0;
    chk("r29_pre_rvalid", 64'(if_rvalid), 64'(1));
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();

    // Long contention saturates the conflict counter.
    if_req = 1'b1; if_addr = 30'h1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h2;
    for (int i = 0; i < 65536 + 5; i++) cycle();
    chk("r30_sat", 64'(conflict_cnt), 64'(16'hFFFF));

    // Random traffic; requests held stable until granted.
    do_reset();
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (g_f || !if_req) begin
        if_req  = ($urandom % 3) != 0;
        if_addr = 30'($urandom % 256);
      end
      if (g_d || !d_req) begin
        d_req   = ($urandom % 3) != 0;
        d_we    = $urandom % 2;
        d_be    = 4'($urandom);
        d_addr  = 30'($urandom % 256);
        d_wdata = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
